// File: rtl/exec_gate.sv
// exec_gate: run/stop/step controller for the controlpath.
//
// Decides on which cycles the current instruction commits. The raw user_clock
// pushbutton (active low) is synchronised and debounced; a press arms the
// controller and the following release resumes. Resume is either free-running
// or a single step, depending on step_mode. Execution halts on a SWCL
// instruction, on any enabled PC breakpoint, or while clock_lock is held.
//
// Ports
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   user_clock     raw pushbutton, asynchronous, 0 = pressed
//   clock_lock     1 = force halt and ignore the button
//   step_mode      1 = a resume executes exactly one instruction
//   halt_request   decoder flags SWCL in the current instruction
//   pc             address of the current instruction
//   bp_addr        packed breakpoint addresses, channel i at [i*PC_WIDTH +: PC_WIDTH]
//   bp_enable      per-channel breakpoint enable
//   exec_enable    current instruction commits this cycle
//   halted         controller is HALTED or ARMED
//   halt_cause     00 none, 01 SWCL, 10 breakpoint, 11 lock/step
//   bp_hit         channels that matched at the last breakpoint halt
//   cycle_count    executed cycles, saturating
module exec_gate #(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 16,
  parameter int N_BREAK   = 4,
  parameter int DEBOUNCE  = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        user_clock,
  input  logic                        clock_lock,
  input  logic                        step_mode,
  input  logic                        halt_request,
  input  logic [PC_WIDTH-1:0]         pc,
  input  logic [N_BREAK*PC_WIDTH-1:0] bp_addr,
  input  logic [N_BREAK-1:0]          bp_enable,
  output logic                        exec_enable,
  output logic                        halted,
  output logic [1:0]                  halt_cause,
  output logic [N_BREAK-1:0]          bp_hit,
  output logic [CNT_WIDTH-1:0]        cycle_count
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SWCL = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  typedef enum logic [1:0] {
    S_HALTED = 2'b00,
    S_ARMED  = 2'b01,
    S_RUN    = 2'b10,
    S_STEP   = 2'b11
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t              state;
  logic                skip;
  logic                btn_p0;
  logic                btn_p1;
  logic                btn_db;
  logic                btn_db_d;
  logic [DB_W-1:0]     db_cnt;
  logic                press;
  logic                release_ev;
  logic [N_BREAK-1:0]  match_vec;
  logic                bp_match;
  logic                active;

  // Stage p0/p1: two-flop synchroniser, then debounce on the p1 sample.
  // An agreeing sample clears the run length, so only DEBOUNCE consecutive
  // disagreeing samples move the debounced level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_p0   <= 1'b1;
      btn_p1   <= 1'b1;
      btn_db   <= 1'b1;
      btn_db_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_p0   <= user_clock;
      btn_p1   <= btn_p0;
      btn_db_d <= btn_db;
      if (btn_p1 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Edges of the debounced level; the FSM acts one cycle after the level moves.
  assign press      = btn_db_d & ~btn_db;
  assign release_ev = ~btn_db_d & btn_db;

  // skip masks breakpoints on the first cycle after a resume so the
  // instruction sitting on the breakpoint can execute.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < N_BREAK; i++) begin
      match_vec[i] = bp_enable[i] && (pc == bp_addr[i*PC_WIDTH +: PC_WIDTH]) && !skip;
    end
  end

  assign bp_match    = |match_vec;
  assign active      = (state == S_RUN) || (state == S_STEP);
  assign exec_enable = active && !clock_lock && !bp_match;
  assign halted      = (state == S_HALTED) || (state == S_ARMED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_HALTED;
      skip        <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      bp_hit      <= '0;
      cycle_count <= '0;
    end else begin
      skip <= 1'b0;
      if (exec_enable) begin
        cycle_count <= sat_inc(cycle_count);
      end
      case (state)
        S_HALTED: begin
          if (press && !clock_lock) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (clock_lock) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_LOCK;
          end else if (release_ev) begin
            state      <= step_mode ? S_STEP : S_RUN;
            skip       <= 1'b1;
            halt_cause <= CAUSE_NONE;
            bp_hit     <= '0;
          end
        end
        S_RUN, S_STEP: begin
          // Lock beats breakpoint beats SWCL; a plain step ends as lock/step.
          if (clock_lock) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_LOCK;
          end else if (bp_match) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_BP;
            bp_hit     <= match_vec;
          end else if (halt_request) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_SWCL;
          end else if (state == S_STEP) begin
            state      <= S_HALTED;
            halt_cause <= CAUSE_LOCK;
          end
        end
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_gate.sv
module tb_exec_gate;

  logic        clock = 1'b0;
  logic        reset;
  logic        user_clock;
  logic        clock_lock;
  logic        step_mode;
  logic        halt_request;
  logic [15:0] pc;
  logic [63:0] bp_addr;
  logic [3:0]  bp_enable;
  logic        exec_enable;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [3:0]  bp_hit;
  logic [5:0]  cycle_count;

  exec_gate #(.PC_WIDTH(16), .CNT_WIDTH(6), .N_BREAK(4), .DEBOUNCE(4)) dut (
    .clock(clock), .reset(reset), .user_clock(user_clock), .clock_lock(clock_lock),
    .step_mode(step_mode), .halt_request(halt_request), .pc(pc), .bp_addr(bp_addr),
    .bp_enable(bp_enable), .exec_enable(exec_enable), .halted(halted),
    .halt_cause(halt_cause), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_halt;
    logic [15:0] pc;
    logic [5:0]  cnt;
    logic [1:0]  cause;
    logic [3:0]  hit;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stimulus configuration, also read by the reference model.
  logic [15:0] cfg_addr [4];
  logic        cfg_en   [4];
  logic        swcl_en;
  logic [15:0] swcl_addr;
  logic        lock_en;
  logic [15:0] lock_addr;

  // Reference model state.
  logic [15:0] m_pc;
  int          m_cnt;
  logic [1:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, expected none", name, what);
  endtask

  // Little CPU: pc advances after every committed cycle; SWCL decode and
  // lock are functions of the pc being presented.
  task automatic tick();
    logic e;
    @(negedge clock);
    e = exec_enable;
    @(posedge clock);
    #1;
    if (e) pc = pc + 16'd1;
    halt_request = swcl_en && (pc == swcl_addr);
    clock_lock   = lock_en && (pc == lock_addr);
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < 4; i++) begin
      bp_addr[i*16 +: 16] = cfg_addr[i];
      bp_enable[i]        = cfg_en[i];
    end
    halt_request = swcl_en && (pc == swcl_addr);
    clock_lock   = lock_en && (pc == lock_addr);
  endtask

  task automatic push_exec(input logic [15:0] a);
    rec_t r;
    r.is_halt = 1'b0; r.pc = a; r.cnt = 6'(m_cnt); r.cause = 2'b00; r.hit = 4'b0;
    exp_q.push_back(r);
    if (m_cnt < 63) m_cnt++;
  endtask

  task automatic push_halt(input logic [1:0] cause, input logic [3:0] hit);
    rec_t r;
    r.is_halt = 1'b1; r.pc = 16'h0; r.cnt = 6'h0; r.cause = cause; r.hit = hit;
    exp_q.push_back(r);
    m_cause = cause;
  endtask

  // Walk the program from the model pc: what executes and why it stops.
  task automatic predict(input bit step);
    logic [15:0] a;
    logic [3:0]  hit;
    bit          first;
    bit          done;
    a = m_pc; first = 1'b1; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      hit = 4'b0;
      for (int i = 0; i < 4; i++) if (cfg_en[i] && cfg_addr[i] == a) hit[i] = 1'b1;
      if (lock_en && a == lock_addr) begin
        push_halt(2'b11, 4'b0); m_pc = a; done = 1'b1;
      end else if (!first && hit != 4'b0) begin
        push_halt(2'b10, hit); m_pc = a; done = 1'b1;
      end else begin
        push_exec(a);
        if (swcl_en && a == swcl_addr) begin
          push_halt(2'b01, 4'b0); m_pc = a + 16'd1; done = 1'b1;
        end else if (step) begin
          push_halt(2'b11, 4'b0); m_pc = a + 16'd1; done = 1'b1;
        end
        a = a + 16'd1;
        first = 1'b0;
      end
    end
  endtask

  task automatic press_release();
    user_clock = 1'b0;
    repeat (8) tick();
    user_clock = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    chk(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < 4; i++) begin
      cfg_addr[i] = 16'hFFF0 + 16'(i);
      cfg_en[i]   = 1'b0;
    end
    swcl_en = 1'b0; swcl_addr = 16'hFFFF;
    lock_en = 1'b0; lock_addr = 16'hFFFF;
  endtask

  // Monitor: pops the scoreboard on every commit and every halt entry.
  initial begin
    rec_t r;
    logic prev_h;
    prev_h = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_h = 1'b1;
      end else begin
        if (exec_enable === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].is_halt) begin
            flag_fail("exec_event", "unexpected commit");
          end else begin
            r = exp_q.pop_front();
            chk("exec_pc", pc, r.pc);
            chk("exec_cycle_count", cycle_count, r.cnt);
          end
        end
        if (halted === 1'b1 && !prev_h) begin
          if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
            flag_fail("halt_event", "unexpected halt");
          end else begin
            r = exp_q.pop_front();
            chk("halt_cause", halt_cause, r.cause);
            chk("halt_bp_hit", bp_hit, r.hit);
          end
        end
        prev_h = halted;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_k;
    int len;
    int ch;
    bit stp;

    reset = 1'b1; user_clock = 1'b1; step_mode = 1'b0;
    pc = 16'h0010; bp_addr = '0; bp_enable = '0;
    clear_cfg();
    apply_cfg();
    m_pc = 16'h0010; m_cnt = 0; m_cause = 2'b00;
    #22;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // T1: reset values, then a short glitch must not arm.
    chk("reset_halted", halted, 1);
    chk("reset_exec_enable", exec_enable, 0);
    chk("reset_halt_cause", halt_cause, 0);
    chk("reset_bp_hit", bp_hit, 0);
    chk("reset_cycle_count", cycle_count, 0);
    user_clock = 1'b0;
    tick();
    tick();
    user_clock = 1'b1;
    repeat (12) tick();
    chk("glitch_halted", halted, 1);

    // T2/T3: free run to a SWCL at 0x1A, measuring release-to-exec latency.
    swcl_en = 1'b1; swcl_addr = 16'h001A;
    apply_cfg();
    predict(1'b0);
    press_release();
    first_k = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (exec_enable && first_k == 0) first_k = k;
    end
    chk("release_to_exec_cycles", first_k, 7);
    wait_done("swcl_run_drain");
    chk("swcl_cause", halt_cause, 2'b01);
    chk("swcl_count", cycle_count, 6'(m_cnt));
    chk("swcl_pc_advanced", pc, 16'h001B);

    // T4: breakpoint on channel 1 at 0x12, then resume through it.
    clear_cfg();
    pc = 16'h0010; m_pc = 16'h0010;
    cfg_addr[1] = 16'h0012; cfg_en[1] = 1'b1;
    apply_cfg();
    predict(1'b0);
    press_release();
    wait_done("bp_run_drain");
    chk("bp_cause", halt_cause, 2'b10);
    chk("bp_hit_vec", bp_hit, 4'b0010);
    chk("bp_pc_held", pc, 16'h0012);
    swcl_en = 1'b1; swcl_addr = 16'h0016;
    apply_cfg();
    predict(1'b0);
    press_release();
    wait_done("bp_resume_drain");
    chk("bp_resume_hit_cleared", bp_hit, 4'b0000);

    // T5: three single steps, a breakpoint on the first step address is skipped.
    clear_cfg();
    cfg_addr[2] = m_pc; cfg_en[2] = 1'b1;
    apply_cfg();
    step_mode = 1'b1;
    for (int s = 0; s < 3; s++) begin
      predict(1'b1);
      press_release();
      wait_done("step_drain");
      chk("step_cause", halt_cause, 2'b11);
    end
    step_mode = 1'b0;

    // T6: lock coincident with breakpoint and SWCL; presses ignored while locked.
    clear_cfg();
    cfg_addr[0] = m_pc + 16'd5; cfg_en[0] = 1'b1;
    swcl_en = 1'b1; swcl_addr = m_pc + 16'd5;
    lock_en = 1'b1; lock_addr = m_pc + 16'd5;
    apply_cfg();
    predict(1'b0);
    press_release();
    wait_done("lock_run_drain");
    chk("lock_cause", halt_cause, 2'b11);
    chk("lock_bp_hit", bp_hit, 4'b0000);
    press_release();
    repeat (12) tick();
    chk("lock_press_ignored", halted, 1);
    lock_en = 1'b0;
    apply_cfg();
    predict(1'b0);
    press_release();
    wait_done("unlock_resume_drain");
    chk("unlock_swcl_cause", halt_cause, 2'b01);

    // Randomised runs: random breakpoints/SWCL ahead of the pc, random step mode.
    for (int it = 0; it < 16; it++) begin
      clear_cfg();
      len = $urandom_range(2, 12);
      for (int i = 0; i < 4; i++) begin
        cfg_addr[i] = m_pc + 16'($urandom_range(0, 14));
        cfg_en[i]   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 1) begin
        swcl_en = 1'b1; swcl_addr = m_pc + 16'(len);
      end else begin
        ch = $urandom_range(0, 3);
        cfg_addr[ch] = m_pc + 16'(len); cfg_en[ch] = 1'b1;
        swcl_en = 1'($urandom_range(0, 1));
        swcl_addr = m_pc + 16'($urandom_range(0, 14));
      end
      stp = ($urandom_range(0, 3) == 0);
      step_mode = stp;
      apply_cfg();
      predict(stp);
      press_release();
      wait_done("rand_drain");
      chk("rand_cause", halt_cause, m_cause);
      step_mode = 1'b0;
    end

    // Long run guarantees the executed-cycle counter reaches saturation.
    clear_cfg();
    swcl_en = 1'b1; swcl_addr = m_pc + 16'd45;
    apply_cfg();
    predict(1'b0);
    press_release();
    wait_done("long_run_drain");
    chk("count_saturated", cycle_count, 6'd63);

    // T6: reset while ARMED discards the pending press.
    clear_cfg();
    apply_cfg();
    user_clock = 1'b0;
    repeat (8) tick();
    #2;
    reset = 1'b1;
    user_clock = 1'b1;
    #1;
    chk("armed_reset_halted", halted, 1);
    chk("armed_reset_exec", exec_enable, 0);
    chk("armed_reset_cause", halt_cause, 0);
    chk("armed_reset_bp_hit", bp_hit, 0);
    chk("armed_reset_count", cycle_count, 0);
    m_cnt = 0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (15) tick();
    chk("after_reset_halted", halted, 1);
    chk("after_reset_count", cycle_count, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
